// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtractor controller. On an accepted start the operands are
// latched and a single full-subtractor cell walks them LSB first, one bit per
// clock, building diff = a - b (mod 2^WIDTH) and the final borrow out. A
// one-cycle done pulse marks the results as valid; they then hold until the
// next accepted start.
//
// Parameters
//   WIDTH   operand width in bits (2..32)
//
// Ports
//   clk     in   sole clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request a subtraction (sampled only while idle)
//   a       in   minuend, captured on accepted start
//   b       in   subtrahend, captured on accepted start
//   busy    out  high while an operation is in progress (SHIFT and DONE)
//   done    out  one-cycle pulse, results valid
//   diff    out  a - b mod 2^WIDTH
//   borrow  out  final borrow, 1 iff a < b (unsigned)
//   ovf     out  signed overflow flag (only with SERIAL_SUB_OVF_EN)
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf port and its logic.
//
// Timing: start sampled at edge N; SHIFT occupies the WIDTH cycles after
// edges N..N+WIDTH-1, DONE the cycle after edge N+WIDTH, and the registered
// done pulse is high in the cycle after edge N+WIDTH+1. That cycle is also
// the first idle cycle, so a start held high is accepted at edge N+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // One full-subtractor cell: returns {bout, d}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bin);
    logic d_v;
    logic bout_v;
    d_v    = ai ^ bi ^ bin;
    bout_v = (~ai & bi) | (~(ai ^ bi) & bin);
    return {bout_v, d_v};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [1:0]       cell_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Subtractor cell fed by the bit currently selected by the counter.
  always_comb begin
    cell_s = fs_cell(a_q[cnt_q], b_q[cnt_q], bin_q);
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Operands are latched here; later changes on a/b are not seen.
          state_d = S_SHIFT;
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        diff_d[cnt_q] = cell_s[0];
        bin_d         = cell_s[1];
        if (cnt_q == CNT_LAST) begin
          // Last bit: its borrow out is the final borrow.
          state_d  = S_DONE;
          cnt_d    = CNT_ZERO;
          borrow_d = cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
          // Signed overflow: operand signs differ and result sign differs
          // from the minuend sign. cell_s[0] is the result MSB.
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_s[0] != a_q[WIDTH-1]);
`endif
        end else begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        // Registered done pulse lands in the cycle after DONE.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT) || (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Directed bench for serial_sub_ctrl (WIDTH=8). A cycle-level reference model
// computes results with plain arithmetic; a compare process checks busy/done
// every cycle and the held results whenever the block is idle. Directed
// scenarios add literal expectations on results and done latency.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: m_t = 0 idle, else number of cycles since acceptance.
  int           m_t;
  logic         m_done;
  logic [W-1:0] m_a, m_b, m_diff;
  logic         m_borrow, m_ovf;

  function automatic logic exp_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // Model update on the active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_done   <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_t == 0) begin
        if (start === 1'b1) begin
          m_t <= 1;
          m_a <= a;
          m_b <= b;
        end
      end else if (m_t == W + 1) begin
        m_t      <= 0;
        m_done   <= 1'b1;
        m_diff   <= m_a - m_b;
        m_borrow <= (m_a < m_b);
        m_ovf    <= exp_ovf(m_a, m_b);
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      tick();
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
  endtask

  // Issue one start pulse, scramble operands afterwards, check results.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = ~x; b = ~y;
    chk("busy_after_start", busy, 1);
    wait_done(n);
    chk("latency", n, 9);
    chk("diff", diff, ed);
    chk("borrow", borrow, eb);
    chk("model_diff", m_diff, ed);
    chk("model_borrow", m_borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, eo);
    chk("model_ovf", m_ovf, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) chk("ovf_arg", eo, 0);
`endif
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; start = 1'b1; a = 8'h03; b = 8'h05;

    // Per-cycle compare against the model.
    fork
      forever begin
        @(negedge clk);
        chk("cyc_busy", busy, (m_t != 0));
        chk("cyc_done", done, m_done);
        if (m_t == 0) begin
          chk("cyc_diff", diff, m_diff);
          chk("cyc_borrow", borrow, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
          chk("cyc_ovf", ovf, m_ovf);
`endif
        end
      end
    join_none

    // Reset state with start held high during reset.
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_borrow", borrow, 0);
    rst_n = 1'b1;
    // First edge with rst_n high accepts the held start.
    tick();
    start = 1'b0;
    chk("first_accept_busy", busy, 1);
    wait_done(n);
    chk("first_latency", n, 9);
    chk("first_diff", diff, 8'hFE);
    chk("first_borrow", borrow, 1);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Start re-pulsed during SHIFT is ignored.
    a = 8'h05; b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", n, 6);
    chk("ign_diff", diff, 8'h02);
    chk("ign_borrow", borrow, 0);
    count_done(W + 4, pulses);
    chk("ign_single_done", pulses, 0);

    // Reset in the 4th SHIFT cycle discards the operation.
    a = 8'h35; b = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_diff", diff, 8'h00);
    chk("midrst_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    count_done(W + 4, pulses);
    chk("midrst_no_done", pulses, 0);
    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    // Back-to-back with start held high.
    a = 8'hA0; b = 8'h0F; start = 1'b1;
    tick();
    a = 8'h10; b = 8'h20;
    wait_done(n);
    chk("b2b1_latency", n, 9);
    chk("b2b1_diff", diff, 8'h91);
    chk("b2b1_borrow", borrow, 0);
    tick();
    start = 1'b0;
    chk("b2b2_accept_busy", busy, 1);
    wait_done(n);
    chk("b2b2_latency", n, 9);
    chk("b2b2_diff", diff, 8'hF0);
    chk("b2b2_borrow", borrow, 1);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: diff  output  WIDTH  result a-b mod 2^WIDTH.
REQ-010 SHALL have port: borrow  output  1  final borrow out; 1 iff a<b unsigned.
REQ-011 SHALL have port: ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL go IDLE->SHIFT when start=1 in IDLE; latch a, b; clear internal borrow bit and bit counter.
REQ-014 SHALL process one bit per SHIFT cycle, LSB first, using one full-subtractor cell: d=a^b^bin, bout=(~a&b)|(~(a^b)&bin).
REQ-015 SHALL write each d into diff bit [counter] and carry bout into the next cycle as bin.
REQ-016 SHALL stay in SHIFT for exactly WIDTH cycles, then go SHIFT->DONE.
REQ-017 SHALL, on entry to DONE, set borrow to bout of bit WIDTH-1 and assert done for exactly one cycle; DONE->IDLE unconditionally.
REQ-018 SHALL have latency: start sampled at edge N, done high in cycle after edge N+WIDTH+1.
REQ-019 SHALL hold diff, borrow (and ovf) stable from done until the next accepted start.
REQ-020 SHALL ignore start while busy=1 (SHIFT or DONE); no re-latch, no queueing.
REQ-021 SHALL accept start asserted in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-022 SHALL make changes on a/b after capture have no effect on the running operation.
REQ-023 SHALL give a=b result diff=0, borrow=0; a=0,b=all-ones result diff=1, borrow=1.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0, counter=0, internal borrow=0.
REQ-025 SHALL, on reset asserted mid-operation, discard the operation; no done pulse after release.
REQ-026 SHALL ignore start in the cycle rst_n deasserts only if sampled while rst_n=0; first rising edge with rst_n=1 may accept start.

Configuration
REQ-027 SHALL, with SERIAL_SUB_OVF_EN defined, provide ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) computed on captured operands, updated with done.
REQ-028 SHALL, without SERIAL_SUB_OVF_EN, omit port ovf and its logic; all other behaviour is identical.

Verification (WIDTH=8)
REQ-029 SHALL verify: a=0x05,b=0x03,start pulse -> done 10 cycles later after edge, diff=0x02, borrow=0.
REQ-030 SHALL verify: a=0x03,b=0x05 -> diff=0xFE, borrow=1; a=0x00,b=0x01 -> diff=0xFF, borrow=1.
REQ-031 SHALL verify: start re-pulsed with a=0xFF,b=0x00 during SHIFT -> ignored; result of original operands reported, single done.
REQ-032 SHALL verify: rst_n low at 4th SHIFT cycle -> busy=0, diff=0 immediately; no done after release; next start completes normally.
REQ-033 SHALL verify: two back-to-back operations, start held high -> second accepted first IDLE cycle after done, both results correct.
REQ-034 SHALL verify (SERIAL_SUB_OVF_EN): a=0x80,b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x05,b=0x03 -> ovf=0.
